// File: rtl/message_encoder.sv
// Five-beat frame encoder: data0..data3 followed by a two's-complement checksum byte.
// Define MESSAGE_ENCODER_PREAMBLE_EN to prepend a 0xA5 sync byte (six-beat frame).
module message_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] frame_cnt
);

  // Handshakes: a beat moves on a rising edge where valid && ready; valid never
  // drops and the payload never changes while waiting for ready.
`ifdef MESSAGE_ENCODER_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PRE = 2'd2} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic       accept;
  logic       xfer;
  logic [9:0] sum10;
  logic [9:0] neg10;
  logic [7:0] next_byte;

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  // Sum is widened to 10 bits, negated, then truncated to the 8-bit checksum.
  assign sum10 = {2'b00, data0} + {2'b00, data1} + {2'b00, data2} + {2'b00, data3};
  assign neg10 = 10'd0 - sum10;

  always_comb begin
    next_byte = csum_q;
    case (idx_q)
      3'd0:    next_byte = d1_q;
      3'd1:    next_byte = d2_q;
      3'd2:    next_byte = d3_q;
      default: next_byte = csum_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    csum_d      = csum_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    in_ready_d  = in_ready_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          d0_d        = data0;
          d1_d        = data1;
          d2_d        = data2;
          d3_d        = data3;
          csum_d      = neg10[7:0];
          idx_d       = 3'd0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          in_ready_d  = 1'b0;
`ifdef MESSAGE_ENCODER_PREAMBLE_EN
          state_d     = PRE;
          out_data_d  = SYNC_BYTE;
`else
          state_d     = SEND;
          out_data_d  = data0;
`endif
        end else begin
          in_ready_d = 1'b1;
        end
      end
`ifdef MESSAGE_ENCODER_PREAMBLE_EN
      PRE: begin
        if (xfer) begin
          state_d    = SEND;
          out_data_d = d0_q;
        end
      end
`endif
      SEND: begin
        if (xfer) begin
          if (idx_q == 3'd4) begin
            state_d     = IDLE;
            idx_d       = 3'd0;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            idx_d      = idx_q + 3'd1;
            out_data_d = next_byte;
            out_last_d = (idx_q == 3'd3);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      d0_q        <= 8'h00;
      d1_q        <= 8'h00;
      d2_q        <= 8'h00;
      d3_q        <= 8'h00;
      csum_q      <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      frame_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      csum_q      <= csum_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_message_encoder.sv
// Scoreboard bench for message_encoder: directed frames, stall, mid-frame reset, 256-frame wrap.
module tb_message_encoder;

`ifdef MESSAGE_ENCODER_PREAMBLE_EN
  localparam bit PRE_EN = 1'b1;
  localparam int NB     = 6;
`else
  localparam bit PRE_EN = 1'b0;
  localparam int NB     = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data0, data1, data2, data3;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] frame_cnt;

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  int         bcnt = 0;
  logic [7:0] fsum = 8'h00;
  logic [7:0] exp_cnt = 8'h00;
  int         stall_left = 0;
  int         held21 = 0;
  bit         rnd_ready = 1'b0;
  bit         prev_hold = 1'b0;
  logic [8:0] prev_beat = 9'h000;

  message_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: picks out_ready for the coming edge, then scores the beat that edge moves.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      bcnt      = 0;
      fsum      = 8'h00;
      exp_cnt   = 8'h00;
      prev_hold = 1'b0;
    end else begin
      check("frame_cnt", frame_cnt, exp_cnt);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_beat", {out_last, out_data}, prev_beat);
      end
      if (!out_valid) begin
        check("idle_data", out_data, 0);
        check("idle_last", out_last, 0);
      end
      if (out_valid && out_data == 8'h21 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        held21++;
      end else if (rnd_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      prev_hold = out_valid && !out_ready;
      prev_beat = {out_last, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {out_last, out_data}, e);
        end
        if (!(PRE_EN && bcnt == 0)) fsum = fsum + out_data;
        bcnt++;
        if (out_last) begin
          check("byte_sum", fsum, 0);
          exp_cnt = exp_cnt + 8'd1;
          bcnt    = 0;
          fsum    = 8'h00;
        end
      end
    end
  end

  task automatic send_msg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic [7:0] cs);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("tmo_in_ready", 0, 1);
      return;
    end
    in_valid = 1'b1;
    data0 = a; data1 = b; data2 = c; data3 = d;
    if (PRE_EN) exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b0, d});
    exp_q.push_back({1'b1, cs});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data0 = 8'($urandom); data1 = 8'($urandom);
    data2 = 8'($urandom); data3 = 8'($urandom);
    check("latency_valid", out_valid, 1);
    check("accept_ready", in_ready, 0);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("tmo_idle", 0, 1);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    data0 = 8'h00; data1 = 8'h00; data2 = 8'h00; data3 = 8'h00;

    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    #9 rst_n = 1'b1;
    #1 check("rel_in_ready_pre", in_ready, 0);
    @(posedge clk);
    #1 check("rel_in_ready", in_ready, 1);

    // Mid-frame reset during the 0x0A beat.
    send_msg(8'h48, 8'h49, 8'h21, 8'h0A, 8'h44);
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_data == 8'h0A) break;
      @(posedge clk);
      #1;
    end
    check("mid_beat3_seen", out_data, 8'h0A);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("mid_rel_ready_pre", in_ready, 0);
    @(posedge clk);
    #1 check("mid_rel_ready", in_ready, 1);

    // Reference frame with continuous out_ready: beats on consecutive cycles.
    send_msg(8'h48, 8'h49, 8'h21, 8'h0A, 8'h44);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
    end
    @(negedge clk);
    check("end_valid", out_valid, 0);
    check("end_in_ready", in_ready, 1);
    check("cnt_after_1", frame_cnt, 1);

    send_msg(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_msg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04);
    wait_idle();
    check("cnt_after_3", frame_cnt, 3);

    stall_left = 3;
    held21 = 0;
    send_msg(8'h48, 8'h49, 8'h21, 8'h0A, 8'h44);
    wait_idle();
    check("stall_cycles", held21, 3);
    check("cnt_after_4", frame_cnt, 4);

    rnd_ready = 1'b1;
    for (int f = 0; f < 252; f++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      send_msg(r0, r1, r2, r3, 8'(8'h00 - r0 - r1 - r2 - r3));
    end
    wait_idle();
    rnd_ready = 1'b0;
    check("cnt_wrap", frame_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/message_encoder.md
MESSAGE_ENCODER -- requirements
Module: message_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  data0..data3 hold a message to encode.
REQ-004 SHALL have port: in_ready  output  1  encoder accepts a message this cycle.
REQ-005 SHALL have ports: data0, data1, data2, data3  input  8 each  message clusters, in transmit order.
REQ-006 SHALL have port: out_valid  output  1  out_data holds a valid frame byte.
REQ-007 SHALL have port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 SHALL have port: out_data  output  8  current frame byte.
REQ-009 SHALL have port: out_last  output  1  current byte is the checksum (final) byte.
REQ-010 SHALL have port: frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-011 SHALL use FSM states IDLE, SEND; optional PRE state per REQ-027.
REQ-012 SHALL drive in_ready=1 only in IDLE; input accept = in_valid && in_ready.
REQ-013 On accept, SHALL register data0..3 and checksum; inputs are ignored afterwards until return to IDLE.
REQ-014 Checksum SHALL be csum = (~(data0+data1+data2+data3) + 1) mod 256, i.e. the 8-bit sum of all five frame bytes is 0x00.
REQ-015 Checksum addition SHALL be carried out at 10-bit width and truncated to 8 bits.
REQ-016 Frame SHALL be 5 beats: data0, data1, data2, data3, csum; a 3-bit beat index counts 0..4.
REQ-017 Transition IDLE->SEND SHALL occur on accept; out_valid SHALL rise the cycle after accept (latency 1).
REQ-018 A beat SHALL transfer when out_valid && out_ready; the index advances only on transfer.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable; out_valid SHALL NOT drop.
REQ-020 out_last SHALL equal 1 exactly while index=4 in SEND.
REQ-021 On transfer of beat 4: SEND->IDLE, out_valid=0 next cycle, frame_cnt increments by 1 (modulo 256).
REQ-022 Back-to-back: in_ready SHALL be 1 the cycle after the last-beat transfer; minimum gap is 1 idle cycle between frames.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 In IDLE, out_data SHALL be 0x00 and out_last 0.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: IDLE, index=0, out_valid=0, out_last=0, out_data=0x00, frame_cnt=0x00, in_ready=0 while asserted, registered data/csum=0x00.
REQ-026 Reset mid-frame SHALL abandon the frame without incrementing frame_cnt; after release, in_ready=1 on the first clock edge.

Configuration
REQ-027 With MESSAGE_ENCODER_PREAMBLE_EN defined, the encoder SHALL prepend a sync byte 0xA5 in state PRE (IDLE->PRE->SEND), giving a 6-beat frame.
REQ-028 0xA5 SHALL be excluded from the checksum and shall obey REQ-019.
REQ-029 Without MESSAGE_ENCODER_PREAMBLE_EN, PRE SHALL not exist and frames SHALL be 5 beats.

Verification
REQ-030 Load 48,49,21,0A with out_ready=1 -> out_data 48,49,21,0A,44 on consecutive cycles; out_last only on 44; frame_cnt 0->1.
REQ-031 Load 00,00,00,00 -> csum 00; load FF,FF,FF,FF -> csum 04.
REQ-032 out_ready=0 for 3 cycles during beat 2 (0x21) -> out_data=21 and out_valid=1 held for 3 cycles; frame completes unchanged.
REQ-033 Assert rst_n=0 during beat 3 -> all outputs 0 immediately, frame_cnt unchanged from pre-frame value; next message encodes correctly.
REQ-034 Run 256 frames -> frame_cnt wraps to 0x00; check every frame's 8-bit byte sum = 0x00.
REQ-035 With MESSAGE_ENCODER_PREAMBLE_EN defined, load 48,49,21,0A -> A5,48,49,21,0A,44; out_last only on 44.
